// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI slave (CPOL=0, CPHA=0, MSB first) with CPU register port
// Optional end-of-packet register/status/port enabled by SPI_SLAVE_EOP_EN.
module spi_slave_port #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
`ifdef SPI_SLAVE_EOP_EN
    output logic        endofpacket,
`endif
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);
    localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);
`ifdef SPI_SLAVE_EOP_EN
    localparam logic [15:0] CTRL_MASK = 16'h03D8;
`else
    localparam logic [15:0] CTRL_MASK = 16'h01D8;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    ss_prev_q, ss_prev_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [4:0]              bitcnt_q, bitcnt_d;
    logic                    reload_q, reload_d;
    logic                    tx_primed_q, tx_primed_d;
    logic                    rrdy_q, rrdy_d;
    logic                    roe_q, roe_d;
    logic                    toe_q, toe_d;
    logic                    tur_q, tur_d;
    logic [15:0]             ctrl_q, ctrl_d;
    logic [15:0]             dout_q, dout_d;
    logic                    irq_q, irq_d;
`ifdef SPI_SLAVE_EOP_EN
    logic [DATA_WIDTH-1:0]   eop_val_q, eop_val_d;
    logic                    eop_q, eop_d;
`endif

    logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic rd, wr, load;
    logic [15:0] status;
    logic [DATA_WIDTH-1:0] shifted;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign rd        = spi_select & ~read_n;
    assign wr        = spi_select & ~write_n;

    generate
        if (DATA_WIDTH == 1) begin : g_shift1
            assign shifted = mosi_s;
        end else begin : g_shiftn
            assign shifted = {shift_q[DATA_WIDTH-2:0], mosi_s};
        end
    endgenerate

    always_comb begin
        status    = '0;
        status[8] = roe_q | toe_q | tur_q;
        status[7] = rrdy_q;
        status[6] = ~tx_primed_q;
        status[5] = ~tx_primed_q & ss_s;
        status[4] = toe_q;
        status[3] = roe_q;
        status[2] = tur_q;
`ifdef SPI_SLAVE_EOP_EN
        status[9] = eop_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        shift_d     = shift_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        bitcnt_d    = bitcnt_q;
        reload_d    = reload_q;
        tx_primed_d = tx_primed_q;
        rrdy_d      = rrdy_q;
        roe_d       = roe_q;
        toe_d       = toe_q;
        tur_d       = tur_q;
        ctrl_d      = ctrl_q;
        dout_d      = dout_q;
        load        = 1'b0;
`ifdef SPI_SLAVE_EOP_EN
        eop_val_d   = eop_val_q;
        eop_d       = eop_q;
`endif

        // CPU-side clears come first so that same-edge serial-side sets win.
        if (rd) begin
            case (mem_addr)
                3'd0:    dout_d = 16'(rx_q);
                3'd2:    dout_d = status;
                3'd3:    dout_d = ctrl_q;
`ifdef SPI_SLAVE_EOP_EN
                3'd6:    dout_d = 16'(eop_val_q);
`endif
                default: dout_d = '0;
            endcase
            if (mem_addr == 3'd0) rrdy_d = 1'b0;
        end
        if (wr) begin
            case (mem_addr)
                3'd2: begin
                    roe_d = 1'b0;
                    toe_d = 1'b0;
                    tur_d = 1'b0;
`ifdef SPI_SLAVE_EOP_EN
                    eop_d = 1'b0;
`endif
                end
                3'd3:    ctrl_d = data_from_cpu & CTRL_MASK;
`ifdef SPI_SLAVE_EOP_EN
                3'd6:    eop_val_d = data_from_cpu[DATA_WIDTH-1:0];
`endif
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d  = SHIFT;
                    load     = 1'b1;
                    bitcnt_d = '0;
                    reload_d = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d  = IDLE;
                    bitcnt_d = '0;
                    reload_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d = shifted;
                    if (bitcnt_q == LAST_BIT) begin
                        rx_d     = shifted;
                        rrdy_d   = 1'b1;
                        if (rrdy_q) roe_d = 1'b1;
                        bitcnt_d = '0;
                        reload_d = 1'b1;
`ifdef SPI_SLAVE_EOP_EN
                        if (shifted == eop_val_q) eop_d = 1'b1;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end else if (sclk_fall && reload_q) begin
                    load     = 1'b1;
                    reload_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (tx_primed_q) begin
                shift_d     = tx_q;
                tx_primed_d = 1'b0;
            end else begin
                shift_d = '0;
                tur_d   = 1'b1;
            end
        end

        // A tx write sees the holding register after any same-edge load.
        if (wr && mem_addr == 3'd1) begin
            if (!tx_primed_d) begin
                tx_d        = data_from_cpu[DATA_WIDTH-1:0];
                tx_primed_d = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end

        irq_d = |(ctrl_q & status & CTRL_MASK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            shift_q     <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            bitcnt_q    <= '0;
            reload_q    <= 1'b0;
            tx_primed_q <= 1'b0;
            rrdy_q      <= 1'b0;
            roe_q       <= 1'b0;
            toe_q       <= 1'b0;
            tur_q       <= 1'b0;
            ctrl_q      <= '0;
            dout_q      <= '0;
            irq_q       <= 1'b0;
`ifdef SPI_SLAVE_EOP_EN
            eop_val_q   <= '0;
            eop_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            bitcnt_q    <= bitcnt_d;
            reload_q    <= reload_d;
            tx_primed_q <= tx_primed_d;
            rrdy_q      <= rrdy_d;
            roe_q       <= roe_d;
            toe_q       <= toe_d;
            tur_q       <= tur_d;
            ctrl_q      <= ctrl_d;
            dout_q      <= dout_d;
            irq_q       <= irq_d;
`ifdef SPI_SLAVE_EOP_EN
            eop_val_q   <= eop_val_d;
            eop_q       <= eop_d;
`endif
        end
    end

    assign data_to_cpu = dout_q;
    assign irq         = irq_q;
    assign MISO        = shift_q[DATA_WIDTH-1];
    assign MISO_oe     = ~ss_s;
`ifdef SPI_SLAVE_EOP_EN
    assign endofpacket = eop_q;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - directed self-checking bench for spi_slave_port
module tb_spi_slave_port;
    logic        clk = 1'b0;
    logic        reset, spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        irq, SCLK, SS_n, MOSI, MISO, MISO_oe;
`ifdef SPI_SLAVE_EOP_EN
    logic        endofpacket;
    localparam logic [15:0] CTRL_ALL = 16'h03D8;
`else
    localparam logic [15:0] CTRL_ALL = 16'h01D8;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mid_status;
    logic        mid_oe;
    logic [15:0] rd_val;
    logic [15:0] miso_bits;

    spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq),
`ifdef SPI_SLAVE_EOP_EN
        .endofpacket(endofpacket),
`endif
        .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [15:0] data);
        spi_select = 1'b1; mem_addr = addr; data_from_cpu = data; write_n = 1'b0;
        tick(1);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic reg_read(input logic [2:0] addr, output logic [15:0] data);
        spi_select = 1'b1; mem_addr = addr; read_n = 1'b0;
        tick(1);
        spi_select = 1'b0; read_n = 1'b1;
        data = data_to_cpu;
    endtask

    // Master: SCLK = 16 clk, SS_n rises together with the final SCLK fall.
    task automatic frame(input int nbits, input logic [15:0] mosi_bits, output logic [15:0] got);
        got  = '0;
        SS_n = 1'b0;
        tick(6);
        mid_oe = MISO_oe;
        reg_read(3'd2, mid_status);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_bits[nbits-1-i];
            tick(8);
            SCLK = 1'b1;
            got[nbits-1-i] = MISO;
            tick(8);
            SCLK = 1'b0;
            if (i == nbits - 1) SS_n = 1'b1;
        end
        tick(6);
    endtask

    initial begin
        reset = 1'b1; spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
        mem_addr = '0; data_from_cpu = '0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_dout", data_to_cpu, 16'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_miso", MISO, 1'b0);
        check("rst_oe", MISO_oe, 1'b0);
        reg_read(3'd2, rd_val); check("rst_status", rd_val, 16'h060);
        reg_read(3'd3, rd_val); check("rst_ctrl", rd_val, 16'h000);
        reg_read(3'd5, rd_val); check("addr5_zero", rd_val, 16'h000);

        // Basic byte exchange
        reg_write(3'd1, 16'h00A5);
        reg_read(3'd2, rd_val); check("primed_status", rd_val, 16'h000);
        frame(8, 16'h003C, miso_bits);
        check("a5_mid_oe", mid_oe, 1'b1);
        check("a5_mid_status", mid_status, 16'h040);
        check("a5_miso", miso_bits, 16'h00A5);
        check("a5_end_oe", MISO_oe, 1'b0);
        reg_read(3'd2, rd_val); check("a5_status", rd_val, 16'h0E0);
        reg_read(3'd0, rd_val); check("rx_3c", rd_val, 16'h003C);
        reg_read(3'd2, rd_val); check("rrdy_cleared", rd_val, 16'h060);

        // RRDY interrupt, underrun
        reg_write(3'd3, 16'h0080);
        reg_read(3'd3, rd_val); check("ctrl_080", rd_val, 16'h080);
        check("irq_idle", irq, 1'b0);
        frame(8, 16'h0055, miso_bits);
        check("tur_miso_zero", miso_bits, 16'h0000);
        check("irq_rrdy", irq, 1'b1);
        reg_read(3'd0, rd_val); check("rx_55", rd_val, 16'h0055);
        tick(1);
        check("irq_fall", irq, 1'b0);
        reg_read(3'd2, rd_val); check("tur_status", rd_val, 16'h164);
        reg_write(3'd2, 16'h0000);
        reg_read(3'd2, rd_val); check("tur_cleared", rd_val, 16'h060);
        reg_write(3'd3, 16'hFFFF);
        reg_read(3'd3, rd_val); check("ctrl_mask", rd_val, CTRL_ALL);
        tick(1);
        check("irq_trdy", irq, 1'b1);
        reg_write(3'd3, 16'h0000);
        tick(2);
        check("irq_off", irq, 1'b0);

        // Two words back-to-back: overrun
        frame(16, 16'h1122, miso_bits);
        check("b2b_miso", miso_bits, 16'h0000);
        reg_read(3'd2, rd_val); check("roe_status", rd_val, 16'h1EC);
        reg_read(3'd0, rd_val); check("rx_22", rd_val, 16'h0022);
        reg_write(3'd2, 16'h0000);
        reg_read(3'd2, rd_val); check("roe_cleared", rd_val, 16'h060);

        // Tx overrun: second write dropped
        reg_write(3'd1, 16'h0001);
        reg_write(3'd1, 16'h0002);
        reg_read(3'd2, rd_val); check("toe_status", rd_val, 16'h110);
        frame(8, 16'h0000, miso_bits);
        check("toe_miso_kept", miso_bits, 16'h0001);
        reg_read(3'd2, rd_val); check("toe_after", rd_val, 16'h1F0);
        reg_write(3'd2, 16'h0000);
        reg_read(3'd0, rd_val); check("rx_00", rd_val, 16'h0000);

        // Aborted frame after 3 rises
        reg_write(3'd1, 16'h00C3);
        frame(3, 16'h0005, miso_bits);
        check("abort_miso", miso_bits, 16'h0006);
        check("abort_oe", MISO_oe, 1'b0);
        reg_read(3'd2, rd_val); check("abort_status", rd_val, 16'h060);

`ifdef SPI_SLAVE_EOP_EN
        reg_write(3'd6, 16'h000D);
        reg_read(3'd6, rd_val); check("eop_val", rd_val, 16'h000D);
        frame(8, 16'h000D, miso_bits);
        check("eop_port", endofpacket, 1'b1);
        reg_read(3'd2, rd_val); check("eop_status", rd_val, 16'h3E4);
        reg_write(3'd2, 16'h0000);
        tick(1);
        check("eop_clear", endofpacket, 1'b0);
        reg_read(3'd0, rd_val);
`endif

        // Reset mid-frame
        reg_write(3'd1, 16'h00FF);
        SS_n = 1'b0; MOSI = 1'b1;
        tick(8);
        SCLK = 1'b1; tick(8); SCLK = 1'b0; tick(8);
        check("mid_miso", MISO, 1'b1);
        reset = 1'b1; SS_n = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst2_miso", MISO, 1'b0);
        check("rst2_oe", MISO_oe, 1'b0);
        tick(3);
        reg_read(3'd2, rd_val); check("rst2_status", rd_val, 16'h060);
        check("rst2_irq", irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
